// File: rtl/conv_kernel_pipe_if.sv
// conv_kernel_pipe_if: bundles the pixel stream, kernel-load and result
// signals of conv_kernel_pipe.
//   master modport : upstream/controller side (drives i_*, observes o_*)
//   slave modport  : the convolver itself (observes i_*, drives o_*)
// Signals:
//   i_ce            pipeline clock enable
//   i_valid         i_subframe carries a valid window
//   i_subframe      KERNEL_SIZE taps, tap j at [j*NB_DATA +: NB_DATA]
//   i_abs_mode      1 = absolute value, 0 = clamp negatives to zero
//   i_coeff_we      shadow kernel write strobe
//   i_coeff_addr    shadow tap index
//   i_coeff_data    signed coefficient
//   i_kernel_commit copy shadow kernel into active kernel
//   o_valid         o_pixel valid
//   o_pixel         convolution result
//   o_kernel_pending shadow written since last commit
interface conv_kernel_pipe_if #(
  parameter int KERNEL_SIZE = 9,
  parameter int NB_DATA     = 8,
  parameter int NB_COEFF    = 8,
  parameter int NB_OUTPUT   = 8
) ();
  localparam int NB_ADDR = $clog2(KERNEL_SIZE);

  logic                          i_ce;
  logic                          i_valid;
  logic [KERNEL_SIZE*NB_DATA-1:0] i_subframe;
  logic                          i_abs_mode;
  logic                          i_coeff_we;
  logic [NB_ADDR-1:0]            i_coeff_addr;
  logic [NB_COEFF-1:0]           i_coeff_data;
  logic                          i_kernel_commit;
  logic                          o_valid;
  logic [NB_OUTPUT-1:0]          o_pixel;
  logic                          o_kernel_pending;

  modport master (
    output i_ce, i_valid, i_subframe, i_abs_mode,
    output i_coeff_we, i_coeff_addr, i_coeff_data, i_kernel_commit,
    input  o_valid, o_pixel, o_kernel_pending
  );

  modport slave (
    input  i_ce, i_valid, i_subframe, i_abs_mode,
    input  i_coeff_we, i_coeff_addr, i_coeff_data, i_kernel_commit,
    output o_valid, o_pixel, o_kernel_pending
  );
endinterface

// File: rtl/conv_kernel_pipe.sv
// conv_kernel_pipe: three-stage pipelined KERNEL_SIZE-tap convolver with a
// double-buffered (shadow/active) signed kernel.
//   S1 multiplies each unsigned pixel by its active coefficient,
//   S2 sums the products at full precision,
//   S3 rounds half up, applies abs/clamp mode, saturates, and registers o_pixel.
// Ports:
//   i_clk    clock
//   i_reset  asynchronous active-low reset
//   bus      conv_kernel_pipe_if slave modport (stream, kernel load, result)
module conv_kernel_pipe #(
  parameter int KERNEL_SIZE = 9,
  parameter int NB_DATA     = 8,
  parameter int NB_COEFF    = 8,
  parameter int NBF_COEFF   = 7,
  parameter int NB_OUTPUT   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  conv_kernel_pipe_if.slave    bus
);
  localparam int NB_ADDR = $clog2(KERNEL_SIZE);
  localparam int NB_PROD = NB_DATA + 1 + NB_COEFF;
  localparam int NB_SUM  = NB_PROD + $clog2(KERNEL_SIZE);

  // One extra bit over the sum so rounding and negation cannot wrap.
  localparam logic signed [NB_SUM:0] RND_C = (NB_SUM+1)'(2**(NBF_COEFF-1));
  localparam logic signed [NB_SUM:0] SAT_C = (NB_SUM+1)'(2**NB_OUTPUT - 1);

  logic signed [NB_COEFF-1:0] shadow_r [KERNEL_SIZE];
  logic signed [NB_COEFF-1:0] active_r [KERNEL_SIZE];
  logic                       pending_r;
  logic                       wr_ok_s;

  logic signed [NB_PROD-1:0]  prod_nxt_s [KERNEL_SIZE];
  logic signed [NB_PROD-1:0]  prod_r     [KERNEL_SIZE];
  logic                       v1_r;
  logic                       abs1_r;

  logic signed [NB_SUM-1:0]   sum_nxt_s;
  logic signed [NB_SUM-1:0]   sum_r;
  logic                       v2_r;
  logic                       abs2_r;

  logic signed [NB_SUM:0]     rnd_s;
  logic signed [NB_SUM:0]     shr_s;
  logic signed [NB_SUM:0]     mag_s;
  logic [NB_OUTPUT-1:0]       pix_nxt_s;
  logic [NB_OUTPUT-1:0]       pix_r;
  logic                       vo_r;

  // Out-of-range tap addresses are dropped entirely, including the pending flag.
  assign wr_ok_s = bus.i_coeff_we &&
                   ({1'b0, bus.i_coeff_addr} < (NB_ADDR+1)'(KERNEL_SIZE));

  // Kernel bank: shadow writes and commit run regardless of i_ce.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int j = 0; j < KERNEL_SIZE; j++) begin
        shadow_r[j] <= '0;
        active_r[j] <= '0;
      end
      pending_r <= 1'b0;
    end else begin
      for (int j = 0; j < KERNEL_SIZE; j++) begin
        if (wr_ok_s && (bus.i_coeff_addr == NB_ADDR'(j))) begin
          shadow_r[j] <= bus.i_coeff_data;
        end
      end
      // Commit copies the pre-edge shadow; a same-cycle write stays pending.
      if (bus.i_kernel_commit) begin
        for (int j = 0; j < KERNEL_SIZE; j++) begin
          active_r[j] <= shadow_r[j];
        end
        pending_r <= wr_ok_s;
      end else if (wr_ok_s) begin
        pending_r <= 1'b1;
      end
    end
  end

  // S1 products: pixel zero-extended to a positive signed operand.
  always_comb begin
    for (int j = 0; j < KERNEL_SIZE; j++) begin
      prod_nxt_s[j] = NB_PROD'($signed({1'b0, bus.i_subframe[j*NB_DATA +: NB_DATA]}))
                    * NB_PROD'(active_r[j]);
    end
  end

  // S2 full-precision sum of the registered products.
  always_comb begin
    sum_nxt_s = '0;
    for (int j = 0; j < KERNEL_SIZE; j++) begin
      sum_nxt_s = sum_nxt_s + NB_SUM'(prod_r[j]);
    end
  end

  // S3 round half up, abs/clamp, saturate to the output range.
  always_comb begin
    rnd_s = (NB_SUM+1)'(sum_r) + RND_C;
    shr_s = rnd_s >>> NBF_COEFF;
    if (shr_s[NB_SUM] == 1'b1) begin
      if (abs2_r) begin
        mag_s = -shr_s;
      end else begin
        mag_s = '0;
      end
    end else begin
      mag_s = shr_s;
    end
    if (mag_s > SAT_C) begin
      pix_nxt_s = SAT_C[NB_OUTPUT-1:0];
    end else begin
      pix_nxt_s = mag_s[NB_OUTPUT-1:0];
    end
  end

  // Pipeline registers; i_ce low freezes every stage and drops i_valid.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int j = 0; j < KERNEL_SIZE; j++) begin
        prod_r[j] <= '0;
      end
      v1_r   <= 1'b0;
      abs1_r <= 1'b0;
      sum_r  <= '0;
      v2_r   <= 1'b0;
      abs2_r <= 1'b0;
      vo_r   <= 1'b0;
      pix_r  <= '0;
    end else if (bus.i_ce) begin
      prod_r <= prod_nxt_s;
      v1_r   <= bus.i_valid;
      abs1_r <= bus.i_abs_mode;
      sum_r  <= sum_nxt_s;
      v2_r   <= v1_r;
      abs2_r <= abs1_r;
      vo_r   <= v2_r;
      // Output pixel holds its last value across invalid slots.
      if (v2_r) begin
        pix_r <= pix_nxt_s;
      end
    end
  end

  assign bus.o_valid          = vo_r;
  assign bus.o_pixel          = pix_r;
  assign bus.o_kernel_pending = pending_r;
endmodule
